// File: rtl/led7_chase.sv
// rtl/led7_chase.sv - multi-digit 7-segment perimeter chaser with prescaler, direction and tail
module led7_chase #(
  parameter int DIGITS     = 2,
  parameter int PRESCALE   = 50000000,
  parameter int TAIL       = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            dir,
  output logic [7*DIGITS-1:0]             seg_o,
  output logic [$clog2(2*DIGITS+4)-1:0]   pos_o,
  output logic                            wrap_o
);

  localparam int L  = 2*DIGITS + 4;
  localparam int PW = $clog2(L);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = 7*DIGITS;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] pos_d;
  logic          wrap_d;
  logic          step;
  logic [SW-1:0] lit;
  logic [SW-1:0] seg_d;

  // Map a clockwise path position to its bit in the flat segment bus.
  function automatic int pos_bit(input int p);
    int b;
    if (p < DIGITS)             b = 7*(DIGITS-1-p);
    else if (p == DIGITS)       b = 1;
    else if (p == DIGITS+1)     b = 2;
    else if (p <= 2*DIGITS+1)   b = 7*(p-DIGITS-2) + 3;
    else if (p == 2*DIGITS+2)   b = 7*(DIGITS-1) + 4;
    else                        b = 7*(DIGITS-1) + 5;
    return b;
  endfunction

  always_comb begin
    step   = en && (cnt_q == CW'(PRESCALE-1));
    cnt_d  = cnt_q;
    pos_d  = pos_o;
    wrap_d = 1'b0;
    if (en) cnt_d = step ? '0 : cnt_q + CW'(1);
    if (step) begin
      if (int'(pos_o) >= L) begin
        pos_d = '0;
      end else if (!dir) begin
        wrap_d = (pos_o == PW'(L-1));
        pos_d  = wrap_d ? '0 : pos_o + PW'(1);
      end else begin
        wrap_d = (pos_o == '0);
        pos_d  = wrap_d ? PW'(L-1) : pos_o - PW'(1);
      end
    end
  end

  // Distance behind the head is measured against the travel direction.
  always_comb begin
    int d;
    lit = '0;
    d   = 0;
    if (int'(pos_o) < L) begin
      for (int q = 0; q < L; q++) begin
        d = dir ? (q - int'(pos_o) + L) % L : (int'(pos_o) - q + L) % L;
        if (d < TAIL) lit[pos_bit(q)] = 1'b1;
      end
    end
    seg_d = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_o  <= '0;
      wrap_o <= 1'b0;
      seg_o  <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      cnt_q  <= cnt_d;
      pos_o  <= pos_d;
      wrap_o <= wrap_d;
      seg_o  <= seg_d;
    end
  end

endmodule

// File: doc/led7_chase.md
Name: led7_chase

Overview:
- Parametrised multi-digit 7-segment "chaser" animator: a lit segment (plus optional tail) runs around the outer perimeter of a row of DIGITS digits.
- Owns its own step prescaler, direction control and enable.
- Sits between the system clock and the board 7-segment pins, with no CPU involvement.

Parameters:
- DIGITS, 2, number of digits in the row (1..8); digit 0 is rightmost.
- PRESCALE, 50000000, enabled clock cycles per animation step (>=1; 1 = step every enabled cycle).
- TAIL, 1, number of lit path positions including the head (1..2*DIGITS+4).
- ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  1 = prescaler runs and head advances; 0 = freeze.
- dir  in  1  0 = clockwise, 1 = counter-clockwise.
- seg_o  out  7*DIGITS  segment drive; digit k at seg_o[7k+6:7k]; bit order within a digit is {g,f,e,d,c,b,a} (bit0 = a).
- pos_o  out  clog2(2*DIGITS+4)  current head position.
- wrap_o  out  1  one-cycle pulse when the head wraps.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state is updated only on the rising edge of clk.
- Path length L = 2*DIGITS+4. With N = DIGITS, clockwise positions are:
  - p = 0..N-1: segment a of digit N-1-p.
  - p = N: b of digit 0.
  - p = N+1: c of digit 0.
  - p = N+2..2N+1: d of digit p-N-2.
  - p = 2N+2: e of digit N-1.
  - p = 2N+3: f of digit N-1.
- Segment g is never lit.
- Reset (rst=1 at an edge): prescaler count = 0, pos_o = 0, wrap_o = 0, seg_o = all segments unlit (all 1s when ACTIVE_LOW=1). This overrides en and any step in progress, mid-run included.
- Prescaler counts edges with en=1 from 0 to PRESCALE-1.
- Step: at an edge with en=1 and count = PRESCALE-1, count returns to 0 and the head advances.
  - dir=0: pos = (pos+1) mod L.
  - dir=1: pos = (pos-1) mod L.
- en=0: count and pos hold their values; wrap_o = 0.
- wrap_o is registered, is 1 only in the cycle following a step that moved the head L-1 -> 0 (dir=0) or 0 -> L-1 (dir=1), is coincident with the new pos_o, and is 0 otherwise.
- Lit set: the head plus the TAIL-1 positions behind it.
  - dir=0: pos, pos-1, ..., pos-TAIL+1 (mod L).
  - dir=1: pos, pos+1, ..., pos+TAIL-1 (mod L).
- A dir change without a step re-orients the tail immediately but does not move the head.
- seg_o is registered: each non-reset edge loads the decode of the current pos_o and dir. seg_o therefore lags pos_o/dir by exactly one cycle; the first lit pattern appears one edge after rst deasserts.
- ACTIVE_LOW=0 inverts every seg_o bit, including the reset value (all 0s).
- dir changing at the same edge as a step: the step uses the dir value sampled at that edge.
- Arithmetic: pos is mod L with no out-of-range states reachable. Any unreachable pos value decodes to all-unlit and steps to 0.

Test Plan:
Default bench instance: DIGITS=2, PRESCALE=4, TAIL=1, ACTIVE_LOW=1, L=8; seg_o written as {digit1, digit0}.
1. rst=1 for 3 edges, then rst=0, en=0 -> pos_o=0, wrap_o=0, seg_o=all 1s during reset; one edge later seg_o={1111110,1111111}.
2. en=1, dir=0 from reset -> pos_o=1 after the 4th edge, then +1 every 4 edges. At pos 2 seg_o={1111111,1111101}, pos 4 {1111111,1110111}, pos 6 {1101111,1111111}, pos 7 {1011111,1111111}. After 32 edges pos 7 -> 0 with a single wrap_o pulse.
3. From pos 0, set dir=1, en=1 -> after 4 edges pos_o=7 and wrap_o=1 for one cycle; the next cycle seg_o={1011111,1111111}.
4. en=1 for 2 edges, en=0 for 10 edges, then en=1 -> pos unchanged while frozen; the step lands exactly 2 enabled edges after re-enable.
5. TAIL=3 instance at pos 2:
   - dir=0 -> seg_o={1111110,1111100}.
   - Switch dir=1 with en=0 -> next cycle seg_o={1111111,1110001}; pos_o still 2.
6. rst pulsed for one edge while at pos 5 with count=2 -> next cycle pos_o=0, wrap_o=0, seg_o all 1s; the next step occurs 4 enabled edges after release.
